// File: rtl/five_stage_memory_arbiter.sv
// Shares one single-ported memory between the five-stage core's fetch port and data port.
// Build option: define FIVE_STAGE_ARB_RR_EN for round-robin arbitration (default: data over fetch).
module five_stage_memory_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int NUM_BYTES    = DATA_WIDTH / 8
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    i_read,
    input  logic [ADDRESS_BITS-1:0] i_address,
    output logic                    i_ready,
    output logic                    i_valid,
    output logic [DATA_WIDTH-1:0]   i_data_out,
    output logic [ADDRESS_BITS-1:0] i_address_out,

    input  logic                    d_read,
    input  logic                    d_write,
    input  logic [NUM_BYTES-1:0]    d_byte_en,
    input  logic [ADDRESS_BITS-1:0] d_address,
    input  logic [DATA_WIDTH-1:0]   d_data_in,
    output logic                    d_ready,
    output logic                    d_valid,
    output logic [DATA_WIDTH-1:0]   d_data_out,
    output logic [ADDRESS_BITS-1:0] d_address_out,

    output logic                    mem_read,
    output logic                    mem_write,
    output logic [NUM_BYTES-1:0]    mem_byte_en,
    output logic [ADDRESS_BITS-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]   mem_data_out,
    input  logic                    mem_ready,
    input  logic                    mem_valid,
    input  logic [DATA_WIDTH-1:0]   mem_data_in,
    input  logic [ADDRESS_BITS-1:0] mem_address_in
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_WAIT = 2'd1,
        D_WAIT = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   last_grant_d;
    logic   last_grant_d_next;

    logic d_req;
    logic i_req;
    logic can_issue;
    logic grant_d;
    logic grant_i;

    // Reset gates issue so nothing leaks onto the memory bus while it is held.
    always_comb begin
        d_req     = d_read | d_write;
        i_req     = i_read;
        can_issue = (state == IDLE) && mem_ready && !reset;
`ifdef FIVE_STAGE_ARB_RR_EN
        if (d_req && i_req) begin
            grant_d = can_issue && !last_grant_d;
        end else begin
            grant_d = can_issue && d_req;
        end
`else
        grant_d = can_issue && d_req;
`endif
        grant_i = can_issue && i_req && !grant_d;
    end

    always_comb begin
        state_next        = state;
        last_grant_d_next = last_grant_d;
        i_ready           = grant_i;
        d_ready           = grant_d;
        i_valid           = 1'b0;
        d_valid           = 1'b0;
        mem_read          = 1'b0;
        mem_write         = 1'b0;
        mem_byte_en       = '0;
        mem_address       = '0;
        mem_data_out      = '0;

        case (state)
            IDLE: begin
                if (grant_d) begin
                    last_grant_d_next = 1'b1;
                    mem_address       = d_address;
                    mem_byte_en       = d_byte_en;
                    // A combined read+write is issued as a posted write only.
                    if (d_write) begin
                        mem_write    = 1'b1;
                        mem_data_out = d_data_in;
                    end else begin
                        mem_read   = 1'b1;
                        state_next = D_WAIT;
                    end
                end else if (grant_i) begin
                    last_grant_d_next = 1'b0;
                    mem_read          = 1'b1;
                    mem_address       = i_address;
                    mem_byte_en       = {NUM_BYTES{1'b1}};
                    state_next        = I_WAIT;
                end
            end
            I_WAIT: begin
                if (mem_valid && !reset) begin
                    i_valid    = 1'b1;
                    state_next = IDLE;
                end
            end
            D_WAIT: begin
                if (mem_valid && !reset) begin
                    d_valid    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            last_grant_d  <= 1'b1;
            i_data_out    <= '0;
            i_address_out <= '0;
            d_data_out    <= '0;
            d_address_out <= '0;
        end else begin
            state        <= state_next;
            last_grant_d <= last_grant_d_next;
            if (i_valid) begin
                i_data_out    <= mem_data_in;
                i_address_out <= mem_address_in;
            end
            if (d_valid) begin
                d_data_out    <= mem_data_in;
                d_address_out <= mem_address_in;
            end
        end
    end

    a_single_owner: assert property (@(posedge clock) disable iff (reset)
        !(i_valid && d_valid));

    a_no_issue_while_waiting: assert property (@(posedge clock) disable iff (reset)
        (state != IDLE) |-> !(mem_read || mem_write || i_ready || d_ready));

    a_write_is_posted: assert property (@(posedge clock) disable iff (reset)
        mem_write |=> (state == IDLE));

endmodule

// File: tb/tb_five_stage_memory_arbiter.sv
// Scoreboard bench for five_stage_memory_arbiter: directed cases followed by randomized traffic.
`timescale 1ns/1ps
module tb_five_stage_memory_arbiter;
    localparam int DW = 32;
    localparam int AW = 20;
    localparam int NB = 4;
`ifdef FIVE_STAGE_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          i_read, i_ready, i_valid;
    logic [AW-1:0] i_address, i_address_out;
    logic [DW-1:0] i_data_out;
    logic          d_read, d_write, d_ready, d_valid;
    logic [NB-1:0] d_byte_en;
    logic [AW-1:0] d_address, d_address_out;
    logic [DW-1:0] d_data_in, d_data_out;
    logic          mem_read, mem_write, mem_ready, mem_valid;
    logic [NB-1:0] mem_byte_en;
    logic [AW-1:0] mem_address, mem_address_in;
    logic [DW-1:0] mem_data_out, mem_data_in;

    always #5 clock = ~clock;

    five_stage_memory_arbiter #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW), .NUM_BYTES(NB)) dut (
        .clock(clock), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_ready(i_ready), .i_valid(i_valid),
        .i_data_out(i_data_out), .i_address_out(i_address_out),
        .d_read(d_read), .d_write(d_write), .d_byte_en(d_byte_en), .d_address(d_address),
        .d_data_in(d_data_in), .d_ready(d_ready), .d_valid(d_valid),
        .d_data_out(d_data_out), .d_address_out(d_address_out),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_en(mem_byte_en),
        .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_ready(mem_ready),
        .mem_valid(mem_valid), .mem_data_in(mem_data_in), .mem_address_in(mem_address_in)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [NB-1:0] be;
    } wr_t;

    logic [AW-1:0] i_q[$];
    logic [AW-1:0] r_q[$];
    wr_t           w_q[$];
    int            n_vec = 0;
    int            n_fail = 0;
    bit            mon_en = 1'b0;

    // Memory contents as the bench's memory responder returns them.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return 32'h9E37_79B9 ^ ({12'd0, a} * 32'h0100_0193);
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = AW'($urandom);
        a[1:0] = 2'b00;
        return a;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        i_read = 0; i_address = '0;
        d_read = 0; d_write = 0; d_byte_en = '0; d_address = '0; d_data_in = '0;
        mem_ready = 0; mem_valid = 0; mem_data_in = '0; mem_address_in = '0;
    endtask

    // Monitor: reference model of who may be granted and who owns the outstanding read.
    bit            busy = 1'b0;
    bit            owner_d = 1'b0;
    bit            last_d = 1'b1;
    bit            i_chk = 1'b0;
    bit            d_chk = 1'b0;
    logic [AW-1:0] i_exp_a, d_exp_a;

    always @(negedge clock) begin
        bit  e_d, e_i, e_wr, e_rd;
        wr_t w;
        if (mon_en) begin
            if (i_chk) begin
                chk("i_data_out", i_data_out, mem_word(i_exp_a));
                chk("i_address_out", i_address_out, i_exp_a);
                i_chk = 0;
            end
            if (d_chk) begin
                chk("d_data_out", d_data_out, mem_word(d_exp_a));
                chk("d_address_out", d_address_out, d_exp_a);
                d_chk = 0;
            end
            if (!busy && mem_ready) begin
                e_d = d_read || d_write;
                if (RR && e_d && i_read) e_d = !last_d;
                e_i  = i_read && !e_d;
                e_wr = e_d && d_write;
                e_rd = e_i || (e_d && !d_write);
                chk("d_ready", d_ready, e_d);
                chk("i_ready", i_ready, e_i);
                chk("mem_write", mem_write, e_wr);
                chk("mem_read", mem_read, e_rd);
                if (e_wr) begin
                    chk("w_q_nonempty", w_q.size() != 0, 1);
                    if (w_q.size() != 0) begin
                        w = w_q.pop_front();
                        chk("wr_address", mem_address, w.a);
                        chk("wr_data", mem_data_out, w.d);
                        chk("wr_byte_en", mem_byte_en, w.be);
                    end
                end
                if (e_rd) begin
                    chk("rd_address", mem_address, e_d ? d_address : i_address);
                    busy    = 1;
                    owner_d = e_d;
                end
                if (e_d || e_i) last_d = e_d;
                chk("valid_in_idle", {i_valid, d_valid}, 0);
            end else if (!busy) begin
                chk("idle_stall", {i_ready, d_ready, mem_read, mem_write, i_valid, d_valid}, 0);
            end else begin
                chk("wait_quiet", {i_ready, d_ready, mem_read, mem_write}, 0);
                chk("i_valid", i_valid, mem_valid && !owner_d);
                chk("d_valid", d_valid, mem_valid && owner_d);
                if (mem_valid) begin
                    busy = 0;
                    if (owner_d) begin
                        chk("r_q_nonempty", r_q.size() != 0, 1);
                        if (r_q.size() != 0) begin d_exp_a = r_q.pop_front(); d_chk = 1; end
                    end else begin
                        chk("i_q_nonempty", i_q.size() != 0, 1);
                        if (i_q.size() != 0) begin i_exp_a = i_q.pop_front(); i_chk = 1; end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            f_hold, d_hold, got_i, got_d, mem_pend, exp_d;
        int            k, lat;
        logic [AW-1:0] pend_addr;

        // Reset with every request and memory input active.
        idle_inputs();
        i_read = 1; d_read = 1; d_write = 1; mem_ready = 1; mem_valid = 1;
        i_address = 'h44; d_address = 'h88; d_data_in = 32'h5555_AAAA; d_byte_en = 4'hF;
        step();
        @(negedge clock);
        chk("rst_ctrl", {i_ready, d_ready, i_valid, d_valid, mem_read, mem_write}, 0);
        chk("rst_mem_fields", {mem_address, mem_byte_en, mem_data_out}, 0);
        chk("rst_data_out", {i_data_out, d_data_out}, 0);
        chk("rst_addr_out", {i_address_out, d_address_out}, 0);
        step();
        idle_inputs();
        reset = 0;

        // Single fetch with 3-cycle memory latency.
        i_read = 1; i_address = 'h40; mem_ready = 1;
        @(negedge clock);
        chk("fetch_i_ready", i_ready, 1);
        chk("fetch_d_ready", d_ready, 0);
        chk("fetch_mem_read", mem_read, 1);
        chk("fetch_mem_addr", mem_address, 'h40);
        step();
        i_read = 0;
        repeat (2) begin
            @(negedge clock);
            chk("fetch_wait", {i_valid, d_valid, mem_read, i_ready}, 0);
            step();
        end
        mem_valid = 1; mem_data_in = 32'hDEAD_BEEF; mem_address_in = 'h40;
        @(negedge clock);
        chk("fetch_i_valid", i_valid, 1);
        chk("fetch_no_d_valid", d_valid, 0);
        step();
        mem_valid = 0;
        @(negedge clock);
        chk("fetch_data", i_data_out, 32'hDEAD_BEEF);
        chk("fetch_addr_out", i_address_out, 'h40);
        chk("fetch_pulse_end", i_valid, 0);
        step();

        // Posted store, then a fetch issued immediately to show the FSM stayed idle.
        d_write = 1; d_byte_en = 4'b0011; d_address = 'h100; d_data_in = 32'hCAFE_F00D;
        @(negedge clock);
        chk("store_mem_write", {mem_write, mem_read}, 2'b10);
        chk("store_d_ready", d_ready, 1);
        chk("store_fields", {mem_address, mem_byte_en, mem_data_out}, {20'h100, 4'b0011, 32'hCAFE_F00D});
        step();
        d_write = 0; i_read = 1; i_address = 'h80;
        @(negedge clock);
        chk("store_stays_idle", i_ready, 1);
        chk("store_no_d_valid", d_valid, 0);
        step();
        i_read = 0; mem_valid = 1; mem_data_in = 32'h1234_5678; mem_address_in = 'h80;
        @(negedge clock);
        chk("store_fetch_resp", {i_valid, d_valid}, 2'b10);
        step();
        mem_valid = 0;

        // Backpressure: load held while memory is not ready.
        d_read = 1; d_address = 'h200; mem_ready = 0;
        repeat (5) begin
            @(negedge clock);
            chk("bp_stall", {mem_read, d_ready, i_ready}, 0);
            step();
        end
        mem_ready = 1;
        @(negedge clock);
        chk("bp_issue", {mem_read, d_ready}, 2'b11);
        chk("bp_addr", mem_address, 'h200);
        step();
        d_read = 0; mem_valid = 1; mem_data_in = 32'h0BAD_F00D; mem_address_in = 'h200;
        @(negedge clock);
        chk("bp_resp", {d_valid, i_valid}, 2'b10);
        step();
        mem_valid = 0;
        @(negedge clock);
        chk("bp_data", d_data_out, 32'h0BAD_F00D);
        chk("bp_addr_out", d_address_out, 'h200);
        step();
        // Stray response in idle is ignored and outputs hold.
        mem_valid = 1; mem_data_in = 32'h7777_7777; mem_address_in = 'h204;
        @(negedge clock);
        chk("stray_valid", {i_valid, d_valid}, 0);
        step();
        mem_valid = 0;
        @(negedge clock);
        chk("stray_hold", d_data_out, 32'h0BAD_F00D);
        step();

        // Three contended rounds straight after reset.
        reset = 1;
        step();
        reset = 0;
        for (int r = 0; r < 3; r++) begin
            i_read = 1; d_read = 1;
            i_address = AW'('h400 + r * 4); d_address = AW'('h800 + r * 4);
            exp_d = RR ? (r == 1) : 1'b1;
            @(negedge clock);
            chk("cont_grant", {i_ready, d_ready}, {!exp_d, exp_d});
            step();
            if (exp_d) d_read = 0; else i_read = 0;
            mem_valid = 1; mem_data_in = 32'hA000_0000 + r; mem_address_in = exp_d ? d_address : i_address;
            @(negedge clock);
            chk("cont_valid", {i_valid, d_valid}, {!exp_d, exp_d});
            chk("cont_wait_ready", {i_ready, d_ready}, 0);
            step();
            mem_valid = 0;
        end
        @(negedge clock);
        chk("cont_loser_grant", {i_ready, d_ready}, RR ? 2'b01 : 2'b10);
        step();
        i_read = 0; d_read = 0; mem_valid = 1; mem_data_in = 32'h1; mem_address_in = 'h0;
        step();
        mem_valid = 0;

        // Reset while a load is outstanding, then a late response.
        d_read = 1; d_address = 'h300; mem_ready = 1;
        @(negedge clock);
        chk("rmid_issue", d_ready, 1);
        step();
        d_read = 0; reset = 1;
        @(negedge clock);
        chk("rmid_ctrl", {i_ready, d_ready, i_valid, d_valid, mem_read, mem_write}, 0);
        step();
        reset = 0; mem_valid = 1; mem_data_in = 32'hBEEF_0300; mem_address_in = 'h300;
        @(negedge clock);
        chk("rmid_late_valid", {d_valid, i_valid}, 0);
        chk("rmid_data_cleared", {d_data_out, i_data_out}, 0);
        chk("rmid_addr_cleared", {d_address_out, i_address_out}, 0);
        step();
        mem_valid = 0; i_read = 1; i_address = 'h310;
        @(negedge clock);
        chk("rmid_back_idle", i_ready, 1);
        step();
        idle_inputs();

        // Randomized traffic checked by the monitor.
        reset = 1;
        step();
        reset = 0;
        mon_en = 1;
        f_hold = 0; d_hold = 0; mem_pend = 0; lat = 0; pend_addr = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc < 3600 && !f_hold && $urandom_range(0, 2) == 0) begin
                f_hold = 1; i_read = 1; i_address = rand_addr();
                i_q.push_back(i_address);
            end
            if (cyc < 3600 && !d_hold && $urandom_range(0, 2) == 0) begin
                wr_t w;
                k = $urandom_range(0, 3);
                d_hold = 1; d_address = rand_addr(); d_data_in = $urandom;
                d_byte_en = NB'($urandom_range(0, 15));
                d_read = (k != 1); d_write = (k == 1 || k == 2);
                if (d_write) begin
                    w.a = d_address; w.d = d_data_in; w.be = d_byte_en;
                    w_q.push_back(w);
                end else begin
                    r_q.push_back(d_address);
                end
            end
            mem_ready = ($urandom_range(0, 3) != 0);
            mem_valid = 0;
            if (mem_pend) begin
                if (lat == 0) begin
                    mem_valid = 1; mem_data_in = mem_word(pend_addr); mem_address_in = pend_addr;
                    mem_pend = 0;
                end else begin
                    lat--;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                mem_valid = 1; mem_data_in = $urandom; mem_address_in = rand_addr();
            end
            @(negedge clock);
            got_i = i_ready; got_d = d_ready;
            if (mem_read) begin
                mem_pend = 1; pend_addr = mem_address; lat = $urandom_range(0, 3);
            end
            step();
            if (got_i) begin f_hold = 0; i_read = 0; end
            if (got_d) begin d_hold = 0; d_read = 0; d_write = 0; end
        end
        repeat (2) step();
        mon_en = 0;
        chk("fetch_all_accepted", f_hold, 0);
        chk("data_all_accepted", d_hold, 0);
        chk("i_q_drained", i_q.size(), 0);
        chk("r_q_drained", r_q.size(), 0);
        chk("w_q_drained", w_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/five_stage_memory_arbiter.md
# five_stage_memory_arbiter

Shares one single-ported main-memory interface between the five-stage core's instruction-fetch port and data-memory port. Sits between the core and the memory/cache and produces the `fetch_valid`/`fetch_ready` and `memory_valid`/`memory_ready` handshakes that the five-stage control unit's hazard logic consumes. Only one request is outstanding at a time. Read responses are steered back to the requester that issued them.

## Interface
Parameters:
- `DATA_WIDTH`, default 32, data bus width.
- `ADDRESS_BITS`, default 20, byte-address width.
- `NUM_BYTES`, default `DATA_WIDTH/8`, byte-enable width.

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `i_read`  in  1  fetch read request; held until `i_ready`.
- `i_address`  in  ADDRESS_BITS  fetch address.
- `i_ready`  out  1  fetch request accepted this cycle.
- `i_valid`  out  1  one-cycle pulse; `i_data_out` valid.
- `i_data_out`  out  DATA_WIDTH  fetched word.
- `i_address_out`  out  ADDRESS_BITS  address of the returned word.
- `d_read`, `d_write`  in  1 each  data request; held until `d_ready`.
- `d_byte_en`  in  NUM_BYTES  store byte enables.
- `d_address`  in  ADDRESS_BITS  data address.
- `d_data_in`  in  DATA_WIDTH  store data.
- `d_ready`  out  1  data request accepted this cycle.
- `d_valid`  out  1  one-cycle pulse; load data valid.
- `d_data_out`  out  DATA_WIDTH  loaded word.
- `d_address_out`  out  ADDRESS_BITS  address of the returned load.
- `mem_read`, `mem_write`  out  1 each  request to memory.
- `mem_byte_en`  out  NUM_BYTES  forwarded byte enables.
- `mem_address`  out  ADDRESS_BITS  forwarded address.
- `mem_data_out`  out  DATA_WIDTH  forwarded store data.
- `mem_ready`  in  1  memory can accept a request this cycle.
- `mem_valid`  in  1  read data returning.
- `mem_data_in`  in  DATA_WIDTH  returned data.
- `mem_address_in`  in  ADDRESS_BITS  returned address.

## Operation
- FSM states:
  - `IDLE`: no read outstanding.
  - `I_WAIT`: waiting for fetch-read data.
  - `D_WAIT`: waiting for load data.
- Issue rule (`IDLE` only):
  - If `mem_ready`=1 and a request is pending, the winner is driven combinationally onto `mem_*` and its `*_ready` is asserted.
  - If `mem_ready`=0, nothing is issued and both readies stay 0.
- Arbitration is fixed priority in the default build: data beats instruction (see Configuration).
- Data write (`d_write`=1):
  - Posted; FSM stays `IDLE`.
  - `d_ready`=1 in the issue cycle.
  - No `d_valid` is generated.
- Reads:
  - A granted fetch read moves the FSM to `I_WAIT`; a granted load moves it to `D_WAIT`.
  - In a WAIT state, `mem_read`=`mem_write`=0 and both readies are 0.
  - When `mem_valid`=1 in a WAIT state:
    - Pulse the owner's `*_valid`.
    - Pass `mem_data_in` to its `*_data_out` and `mem_address_in` to its `*_address_out`.
    - Return to `IDLE`.
- `d_read` and `d_write` asserted together: treated as a write; the read is dropped from that request.
- `mem_valid` in `IDLE` is ignored; neither requester's `*_valid` pulses.
- Both `*_data_out`/`*_address_out` are registered copies of the last response, so they hold while `*_valid`=0.
- Reset values:
  - State `IDLE`.
  - All outputs 0.
  - The last-grant register points to data.
- Reset mid-operation: any outstanding read is abandoned, and a late `mem_valid` after reset is ignored.

## Timing
- Issue is zero-latency: a request presented in `IDLE` with `mem_ready`=1 appears on `mem_*` in the same cycle.
- Read latency = memory latency. `*_valid` is combinational from `mem_valid` in the WAIT state; `*_data_out` is registered and updates at the end of that cycle.
- After a read response there is one `IDLE` cycle minimum before the next read completes. A new issue is allowed in the first `IDLE` cycle.
- Back-to-back writes: one per cycle while `mem_ready`=1.
- Requests must remain stable until `*_ready`. The arbiter samples no request state outside the issue cycle.

## Configuration
- Macro: `FIVE_STAGE_ARB_RR_EN`.
- Defined: round-robin arbitration. On contention, the requester not named in the last-grant register wins. The register updates on every grant.
- Undefined: fixed priority, data over instruction. The last-grant register is still implemented but is not used for arbitration.

## Test plan
- Single fetch: `i_read`=1, address 0x40, memory returns 0xDEADBEEF after 3 cycles → `i_ready` in cycle 0, `i_valid` pulse in cycle 3, `i_data_out`=0xDEADBEEF, `d_valid` stays 0.
- Contention, macro undefined: `i_read`=`d_read`=1 in `IDLE` → `d_ready`=1 first; `i_ready`=1 only after `d_valid`.
- Contention, macro defined: three consecutive contended rounds after reset → grant order I, D, I.
- Posted store: `d_write`=1, `d_byte_en`=4'b0011, address 0x100 → `mem_write`=1 with identical fields in the same cycle, `d_ready`=1, FSM stays `IDLE`, no `d_valid`.
- Backpressure: `mem_ready`=0 for 5 cycles with `d_read` pending → no `mem_read`, `d_ready`=0, then issue in the first cycle `mem_ready`=1.
- Reset mid-read: assert `reset` during `D_WAIT`, then `mem_valid`=1 → no `d_valid`, all outputs 0, FSM `IDLE`.
